// File: rtl/fact_bcd_convert.sv
// Sequential double-dabble: converts a WIDTH-bit binary value to packed BCD, one bit per clock.
// Latency: done pulses WIDTH cycles after the accepting edge; one conversion per WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE, requests during SHIFT/DONE are dropped.
module fact_bcd_convert #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [BW-1:0]   acc, acc_nxt, adj, acc_shift;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [BW-1:0]   bcd_nxt;
    logic            done_nxt;

    // Add-3 on every digit from its pre-shift value; no carry between digits.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    assign acc_shift = {adj[BW-2:0], sr[WIDTH-1]};

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        bcd_nxt   = bcd;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nxt    = bin;
                    acc_nxt   = '0;
                    cnt_nxt   = CW'(WIDTH);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt = acc_shift;
                sr_nxt  = {sr[WIDTH-2:0], 1'b0};
                cnt_nxt = cnt - CW'(1);
                // Last iteration: publish the result straight from the shift path.
                if (cnt == CW'(1)) begin
                    bcd_nxt   = acc_shift;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            bcd   <= bcd_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_fact_bcd_convert.sv
// Bench for fact_bcd_convert: vector table plus handwritten corner sequences, scoreboard on done.
module tb_fact_bcd_convert;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    fact_bcd_convert #(.WIDTH(16), .DIGITS(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_count = 0;
    logic [19:0] expq[$];
    int dcyc[$];

    typedef struct {
        logic [15:0] v;
        logic [19:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            dcyc.push_back(cyc);
            if (expq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = expq.pop_front();
                chk("bcd_result", {12'd0, bcd}, {12'd0, e});
            end
        end
    end

    // One conversion with latency, busy and done-width checks.
    task automatic do_conv(input logic [15:0] v, input logic [19:0] exp);
        int n;
        logic busy_ok;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = v;
        expq.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 16'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (expq.size() > 0) void'(expq.pop_front());
        end else begin
            chk("latency_edges", 32'(n - 1), 32'd16);
            chk("busy_during_shift", {31'd0, busy_ok}, 32'd1);
            chk("busy_low_at_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        vec_t vt[10];
        int dc0;
        vt[0] = '{16'd0,     20'h00000};
        vt[1] = '{16'd24,    20'h00024};
        vt[2] = '{16'd720,   20'h00720};
        vt[3] = '{16'd40320, 20'h40320};
        vt[4] = '{16'hFFFF,  20'h65535};
        vt[5] = '{16'd9,     20'h00009};
        vt[6] = '{16'd1234,  20'h01234};
        vt[7] = '{16'd10000, 20'h10000};
        vt[8] = '{16'd59999, 20'h59999};
        vt[9] = '{16'd99,    20'h00099};

        reset_n = 1'b0;
        start   = 1'b0;
        bin     = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_bcd", {12'd0, bcd}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            do_conv(vt[i].v, vt[i].exp);
            repeat (2) @(posedge clk);
        end

        // Second start during SHIFT is ignored.
        dc0 = done_count;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd720;
        expq.push_back(20'h00720);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'd1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_start_done_count", 32'(done_count - dc0), 32'd1);
        chk("ignored_start_bcd", {12'd0, bcd}, 32'h00720);

        // Reset mid-conversion aborts it.
        do_conv(16'd24, 20'h00024);
        dc0 = done_count;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd40320;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        chk("pre_reset_bcd", {12'd0, bcd}, 32'h00024);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bcd", {12'd0, bcd}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(done_count - dc0), 32'd0);
        chk("abort_bcd_hold", {12'd0, bcd}, 32'd0);
        do_conv(16'd9, 20'h00009);

        // Start held high: back-to-back conversions every 18 cycles.
        repeat (2) @(posedge clk);
        dcyc.delete();
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd24;
        repeat (3) expq.push_back(20'h00024);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_done_count", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            chk("held_spacing_1", 32'(dcyc[1] - dcyc[0]), 32'd18);
            chk("held_spacing_2", 32'(dcyc[2] - dcyc[1]), 32'd18);
        end

        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fact_bcd_convert.md
Name: fact_bcd_convert

Overview:
Downstream stage of the factorial unit. Converts the 16-bit binary factorial result to packed BCD for display or printing, using sequential shift-add-3 (double-dabble), one bit per clock. Its bin input is wired to the factorial unit's fact output, and its start input is wired to the factorial unit's done output. It has its own start/busy/done handshake, so a display or UART stage can consume it the same way.

Parameters:
WIDTH, 16, binary input width; one shift iteration per bit.
DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1 (5 for 16 bits).

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
bin  input  WIDTH  binary value; captured on the accepting edge
busy  output  1  high while conversion in progress (SHIFT state)
done  output  1  one-cycle pulse when bcd holds the new result
bcd  output  4*DIGITS  packed BCD; digit 0 is bcd[3:0] (LSD)

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0; done=0; bcd=0; internal shift register and counter = 0. Reset mid-conversion aborts it. No done is produced, and bcd reads 0.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge (call it edge 0):
  - latch bin into the binary shift register;
  - clear the BCD accumulator;
  - load counter=WIDTH;
  - go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT: each edge performs one iteration:
  - every 4-bit accumulator digit >= 5 gets +3 (all digits in parallel, from pre-shift values);
  - then {accumulator, binary} shifts left by 1;
  - then the counter decrements.
  - The iteration at which the counter reaches 0 is the WIDTH-th (edge WIDTH). On that same edge, the final accumulator is written to bcd, done<=1, and the state goes to DONE.
- DONE: at the next edge (WIDTH+1), done<=0 and the state goes to IDLE. done is high for exactly one cycle.
- Latency: done is high in the cycle following edge WIDTH, i.e. WIDTH cycles after the accepting edge (16 cycles by default). Throughput is one conversion per WIDTH+2 cycles.
- busy = (state==SHIFT). It is 1 from after edge 0 through edge WIDTH.
- bcd changes only on the completion edge or on reset. It holds the previous result during a conversion; intermediate accumulator values are never visible.
- start while in SHIFT or DONE is ignored and not queued. bin changes after the accepting edge have no effect.
- start held continuously high: a new conversion is accepted on the first IDLE edge after DONE, with bin resampled.
- Digit arithmetic is 4-bit with no carry between digits during add-3; the shift carries the digit MSB into the next digit's LSB. Any input with 0 <= bin <= 2^WIDTH-1 yields exact BCD with no overflow.

Test Plan:
- Reset, then bin=16'd0 with start pulsed 1 cycle -> busy=1 for 16 cycles; done pulses 1 cycle, 16 cycles after the accept edge; bcd=20'h00000.
- Chain with the factorial unit, data=4 then data=6 -> bcd=20'h00024, then 20'h00720. Each done is a single-cycle pulse; busy=0 in IDLE.
- bin=16'd40320 (8!) -> bcd=20'h40320. bin=16'hFFFF -> bcd=20'h65535. bin=16'd9 -> bcd=20'h00009.
- Start at bin=720; at cycle 5 raise start again with bin=1234 -> second request is ignored; bcd=20'h00720; exactly one done pulse.
- Start conversion of 40320, previous bcd=20'h00024; assert reset_n=0 at cycle 8 for 2 cycles -> immediately busy=0, done=0, bcd=0; no done follows. After release, IDLE accepts the next start normally.
- Hold start=1 with bin=24 -> back-to-back conversions every 18 cycles, each ending with bcd=20'h00024 and one done pulse.
